// File: rtl/stack_alu_sequencer_if.sv
// Bus bundle between the RPN front end and its neighbours.
// Groups three channels:
//   token stream  : tok_valid, tok_ready, tok_kind, tok_data
//   ALU commands  : alu_opcode, alu_data (to ALU); alu_output, alu_overflow (from ALU)
//   result stream : res_valid, res_ready, res_data, res_overflow, res_err
// Modports:
//   master : environment side (token source, ALU, result sink)
//   slave  : the sequencer
interface stack_alu_sequencer_if #(
  parameter int N = 4
);
  logic         tok_valid;
  logic         tok_ready;
  logic [1:0]   tok_kind;
  logic [N-1:0] tok_data;

  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_output;
  logic         alu_overflow;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_overflow;
  logic [1:0]   res_err;

  modport master (
    output tok_valid, tok_kind, tok_data, alu_output, alu_overflow, res_ready,
    input  tok_ready, alu_opcode, alu_data, res_valid, res_data, res_overflow, res_err
  );

  modport slave (
    input  tok_valid, tok_kind, tok_data, alu_output, alu_overflow, res_ready,
    output tok_ready, alu_opcode, alu_data, res_valid, res_data, res_overflow, res_err
  );
endinterface

// File: rtl/stack_alu_sequencer.sv
// RPN command sequencer for the stack ALU.
// Takes a postfix token stream, turns each token into a one-cycle ALU
// command, tracks stack depth locally so underflow/overflow never reach
// the ALU, pops the final value and returns one result per expression.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : token, ALU command and result channels (slave modport)
//
// state  | meaning
// ACCEPT | tok_ready high, waiting for a token
// ISSUE  | selected opcode on alu_opcode for one cycle, depth updated
// WAIT   | ALU result/overflow valid, sampled at end of cycle
// FLUSH  | one POP per cycle until the ALU stack is empty
// RESULT | res_valid high, held until res_ready
module stack_alu_sequencer #(
  parameter int N          = 4,
  parameter int STACK_SIZE = 16
) (
  input logic clk,
  input logic rst,
  stack_alu_sequencer_if.slave bus
);

  localparam int DW = $clog2(STACK_SIZE + 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_FULL  = 2'b01;
  localparam logic [1:0] E_UNDER = 2'b10;
  localparam logic [1:0] E_END   = 2'b11;

  typedef enum logic [2:0] {
    ST_ACCEPT,
    ST_ISSUE,
    ST_WAIT,
    ST_RESULT,
    ST_FLUSH
  } state_t;

  state_t       state_q, state_nx;
  logic [DW-1:0] depth_q, depth_nx;
  // Opcode in flight; WAIT uses it to tell an arithmetic op from the final POP.
  logic [2:0]   op_q, op_nx;
  logic [2:0]   alu_opcode_q, alu_opcode_nx;
  logic [N-1:0] alu_data_q, alu_data_nx;
  logic         tok_ready_q, tok_ready_nx;
  logic         res_valid_q, res_valid_nx;
  logic [N-1:0] res_data_q, res_data_nx;
  logic         res_overflow_q, res_overflow_nx;
  logic [1:0]   res_err_q, res_err_nx;
  logic         abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_ACCEPT;
      depth_q        <= '0;
      op_q           <= OP_NOP;
      alu_opcode_q   <= OP_NOP;
      alu_data_q     <= '0;
      tok_ready_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_overflow_q <= 1'b0;
      res_err_q      <= E_OK;
    end else begin
      state_q        <= state_nx;
      depth_q        <= depth_nx;
      op_q           <= op_nx;
      alu_opcode_q   <= alu_opcode_nx;
      alu_data_q     <= alu_data_nx;
      tok_ready_q    <= tok_ready_nx;
      res_valid_q    <= res_valid_nx;
      res_data_q     <= res_data_nx;
      res_overflow_q <= res_overflow_nx;
      res_err_q      <= res_err_nx;
    end
  end

  always_comb begin
    state_nx        = state_q;
    depth_nx        = depth_q;
    op_nx           = op_q;
    alu_opcode_nx   = OP_NOP;
    alu_data_nx     = '0;
    tok_ready_nx    = 1'b0;
    res_valid_nx    = res_valid_q;
    res_data_nx     = res_data_q;
    res_overflow_nx = res_overflow_q;
    res_err_nx      = res_err_q;
    abort           = 1'b0;

    unique case (state_q)
      ST_ACCEPT: begin
        tok_ready_nx = 1'b1;
        if (bus.tok_valid && tok_ready_q) begin
          tok_ready_nx = 1'b0;
          unique case (bus.tok_kind)
            K_OPND: begin
              if (depth_q == DW'(STACK_SIZE)) begin
                res_err_nx = E_FULL;
                abort      = 1'b1;
              end else begin
                op_nx         = OP_PUSH;
                alu_opcode_nx = OP_PUSH;
                alu_data_nx   = bus.tok_data;
                state_nx      = ST_ISSUE;
              end
            end
            K_ADD, K_MUL: begin
              if (depth_q < DW'(2)) begin
                res_err_nx = E_UNDER;
                abort      = 1'b1;
              end else begin
                op_nx         = (bus.tok_kind == K_ADD) ? OP_ADD : OP_MUL;
                alu_opcode_nx = (bus.tok_kind == K_ADD) ? OP_ADD : OP_MUL;
                state_nx      = ST_ISSUE;
              end
            end
            K_END: begin
              if (depth_q == '0) begin
                res_err_nx   = E_END;
                res_data_nx  = '0;
                res_valid_nx = 1'b1;
                state_nx     = ST_RESULT;
              end else if (depth_q != DW'(1)) begin
                res_err_nx = E_END;
                abort      = 1'b1;
              end else begin
                op_nx         = OP_POP;
                alu_opcode_nx = OP_POP;
                state_nx      = ST_ISSUE;
              end
            end
          endcase
        end
        // An empty stack has nothing to flush, so report straight away.
        if (abort) begin
          if (depth_q == '0) begin
            res_data_nx  = '0;
            res_valid_nx = 1'b1;
            state_nx     = ST_RESULT;
          end else begin
            alu_opcode_nx = OP_POP;
            state_nx      = ST_FLUSH;
          end
        end
      end

      ST_ISSUE: begin
        if (op_q == OP_PUSH) begin
          depth_nx     = depth_q + DW'(1);
          tok_ready_nx = 1'b1;
          state_nx     = ST_ACCEPT;
        end else begin
          depth_nx = depth_q - DW'(1);
          state_nx = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (op_q == OP_POP) begin
          res_data_nx  = bus.alu_output;
          res_valid_nx = 1'b1;
          state_nx     = ST_RESULT;
        end else begin
          res_overflow_nx = res_overflow_q | bus.alu_overflow;
          tok_ready_nx    = 1'b1;
          state_nx        = ST_ACCEPT;
        end
      end

      // The POP for the current cycle is already on alu_opcode; decide
      // whether another one follows.
      ST_FLUSH: begin
        depth_nx = depth_q - DW'(1);
        if (depth_q == DW'(1)) begin
          res_data_nx  = '0;
          res_valid_nx = 1'b1;
          state_nx     = ST_RESULT;
        end else begin
          alu_opcode_nx = OP_POP;
        end
      end

      ST_RESULT: begin
        if (bus.res_ready) begin
          res_valid_nx    = 1'b0;
          res_overflow_nx = 1'b0;
          res_err_nx      = E_OK;
          depth_nx        = '0;
          tok_ready_nx    = 1'b1;
          state_nx        = ST_ACCEPT;
        end
      end

      default: state_nx = ST_ACCEPT;
    endcase
  end

  assign bus.tok_ready    = tok_ready_q;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_data     = alu_data_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_overflow = res_overflow_q;
  assign bus.res_err      = res_err_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Testbench for stack_alu_sequencer: behavioural ALU, expression-level
// reference model, per-cycle compare process, directed and random expressions.
module tb_stack_alu_sequencer;
  localparam int N  = 4;
  localparam int SS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_alu_sequencer_if #(.N(N)) bus();

  stack_alu_sequencer #(.N(N), .STACK_SIZE(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {logic [1:0] kind; logic [N-1:0] data;} tok_t;
  typedef struct packed {logic [2:0] op; logic [N-1:0] data;} op_t;
  typedef struct packed {logic [N-1:0] data; logic ovf; logic [1:0] err;} res_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pop_run = 0;
  int last_run = 0;

  op_t  exp_ops[$];
  res_t exp_res[$];
  tok_t toks[$];
  op_t  m_ops[$];
  int   m_used;
  res_t m_res;
  int   alu_stk[$];
  op_t  cmp_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [2:0] op, input logic [N-1:0] d);
    op_t o;
    o.op = op;
    o.data = d;
    return o;
  endfunction

  task automatic add(input logic [1:0] kind, input logic [N-1:0] d);
    tok_t t;
    t.kind = kind;
    t.data = d;
    toks.push_back(t);
  endtask

  // Behavioural ALU: acts on the opcode held during ISSUE.
  always @(negedge clk) begin
    int a, b, r;
    if (!rst) begin
      alu_stk.delete();
      bus.alu_output   = '0;
      bus.alu_overflow = 1'b0;
    end else begin
      case (bus.alu_opcode)
        3'b110: begin
          alu_stk.push_back(int'(bus.alu_data));
          bus.alu_overflow = 1'b0;
        end
        3'b100, 3'b101: if (alu_stk.size() >= 2) begin
          b = alu_stk.pop_back();
          a = alu_stk.pop_back();
          r = (bus.alu_opcode == 3'b100) ? a + b : a * b;
          alu_stk.push_back(r % (1 << N));
          bus.alu_output   = N'(r);
          bus.alu_overflow = (r >= (1 << N));
        end
        3'b111: if (alu_stk.size() >= 1) begin
          bus.alu_output = N'(alu_stk.pop_back());
        end
        default: ;
      endcase
    end
  end

  // Expression-level reference: evaluates toks with a plain stack and
  // produces the ALU command list, the tokens consumed and the result.
  function automatic void model();
    int stk[$];
    int a, b, r;
    bit done = 0;
    m_ops.delete();
    m_used = 0;
    m_res = '0;
    foreach (toks[i]) begin
      if (!done) begin
        m_used = i + 1;
        case (toks[i].kind)
          2'b00: begin
            if (stk.size() == SS) begin
              m_res.err = 2'b01;
              done = 1;
            end else begin
              stk.push_back(int'(toks[i].data));
              m_ops.push_back(mk(3'b110, toks[i].data));
            end
          end
          2'b01, 2'b10: begin
            if (stk.size() < 2) begin
              m_res.err = 2'b10;
              done = 1;
            end else begin
              b = stk.pop_back();
              a = stk.pop_back();
              r = (toks[i].kind == 2'b01) ? a + b : a * b;
              if (r >= (1 << N)) m_res.ovf = 1'b1;
              stk.push_back(r % (1 << N));
              m_ops.push_back(mk((toks[i].kind == 2'b01) ? 3'b100 : 3'b101, '0));
            end
          end
          default: begin
            done = 1;
            if (stk.size() == 1) begin
              m_ops.push_back(mk(3'b111, '0));
              m_res.data = N'(stk[0]);
              stk.delete();
            end else begin
              m_res.err = 2'b11;
            end
          end
        endcase
      end
    end
    repeat (stk.size()) m_ops.push_back(mk(3'b111, '0));
  endfunction

  // Per-cycle compare against the model's queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.alu_opcode != 3'b000) begin
        if (exp_ops.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_op: got %b expected none", bus.alu_opcode);
        end else begin
          cmp_e = exp_ops.pop_front();
          chk("alu_opcode", 32'(bus.alu_opcode), 32'(cmp_e.op));
          chk("alu_data", 32'(bus.alu_data), 32'(cmp_e.data));
        end
      end else begin
        chk("alu_data_idle", 32'(bus.alu_data), 0);
      end
      if (bus.alu_opcode == 3'b111) pop_run++;
      else if (pop_run != 0) begin
        last_run = pop_run;
        pop_run = 0;
      end
      if (bus.res_valid) begin
        if (exp_res.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got data %0h expected no result", bus.res_data);
        end else begin
          chk("res_data", 32'(bus.res_data), 32'(exp_res[0].data));
          chk("res_overflow", 32'(bus.res_overflow), 32'(exp_res[0].ovf));
          chk("res_err", 32'(bus.res_err), 32'(exp_res[0].err));
        end
        chk("tok_ready_in_result", 32'(bus.tok_ready), 0);
      end
    end
  end

  always @(posedge clk) begin
    if (rst && bus.res_valid && bus.res_ready && exp_res.size() > 0)
      void'(exp_res.pop_front());
  end

  task automatic send_tok(input tok_t t);
    int n = 0;
    bus.tok_valid = 1'b1;
    bus.tok_kind  = t.kind;
    bus.tok_data  = t.data;
    while (!bus.tok_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL tok_accept_timeout: got tok_ready=0 for %0d cycles expected 1", n);
    end
    @(negedge clk);
    bus.tok_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, output int lat, output res_t got);
    int n = 0;
    while (!bus.res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    got = '0;
    if (!bus.res_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL res_timeout: got res_valid=0 after %0d cycles expected 1", n);
      bus.res_ready = 1'b1;
      return;
    end
    got.data = bus.res_data;
    got.ovf  = bus.res_overflow;
    got.err  = bus.res_err;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 1);
      chk("hold_data", 32'(bus.res_data), 32'(got.data));
      chk("hold_err", 32'(bus.res_err), 32'(got.err));
      chk("hold_tok_ready", 32'(bus.tok_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("res_valid_drop", 32'(bus.res_valid), 0);
    chk("tok_ready_after_result", 32'(bus.tok_ready), 1);
  endtask

  task automatic run_expr(input int hold, output int lat, output int tot, output res_t got);
    int c0;
    model();
    foreach (m_ops[i]) exp_ops.push_back(m_ops[i]);
    exp_res.push_back(m_res);
    last_run = 0;
    bus.res_ready = (hold == 0);
    c0 = cyc;
    for (int i = 0; i < m_used; i++) send_tok(toks[i]);
    wait_result(hold, lat, got);
    tot = cyc - c0 - 1 + ((hold == 0) ? 0 : 0) - hold;
    chk("ops_drained", exp_ops.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat, tot;
    res_t got;
    tok_t t;
    bus.tok_valid = 1'b0;
    bus.tok_kind  = 2'b00;
    bus.tok_data  = '0;
    bus.res_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_tok_ready", 32'(bus.tok_ready), 0);
    chk("rst_alu_opcode", 32'(bus.alu_opcode), 0);
    chk("rst_alu_data", 32'(bus.alu_data), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_res_overflow", 32'(bus.res_overflow), 0);
    chk("rst_res_err", 32'(bus.res_err), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("tok_ready_after_rst", 32'(bus.tok_ready), 1);

    // Asynchronous reset in the middle of a PUSH issue.
    exp_ops.push_back(mk(3'b110, 4'd9));
    t.kind = 2'b00;
    t.data = 4'd9;
    send_tok(t);
    chk("issue_push_opcode", 32'(bus.alu_opcode), 32'h6);
    #1 rst = 1'b0;
    #1;
    chk("async_alu_opcode", 32'(bus.alu_opcode), 0);
    chk("async_alu_data", 32'(bus.alu_data), 0);
    chk("async_tok_ready", 32'(bus.tok_ready), 0);
    chk("async_res_valid", 32'(bus.res_valid), 0);
    chk("async_res_err", 32'(bus.res_err), 0);
    @(negedge clk);
    exp_ops.delete();
    exp_res.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("tok_ready_after_rst2", 32'(bus.tok_ready), 1);

    toks.delete(); add(2'b00, 4'd3); add(2'b11, 4'd0);
    run_expr(0, lat, tot, got);
    chk("post_rst_data", 32'(got.data), 3);
    chk("post_rst_err", 32'(got.err), 0);
    chk("end_latency", lat, 2);

    toks.delete(); add(2'b00, 4'd4); add(2'b00, 4'd3); add(2'b01, 4'd5); add(2'b11, 4'd0);
    model();
    chk("model_ops_len", m_ops.size(), 4);
    chk("model_op0", 32'(m_ops[0]), 32'(mk(3'b110, 4'd4)));
    chk("model_op1", 32'(m_ops[1]), 32'(mk(3'b110, 4'd3)));
    chk("model_op2", 32'(m_ops[2]), 32'(mk(3'b100, 4'd0)));
    chk("model_op3", 32'(m_ops[3]), 32'(mk(3'b111, 4'd0)));
    run_expr(0, lat, tot, got);
    chk("add_data", 32'(got.data), 7);
    chk("add_ovf", 32'(got.ovf), 0);
    chk("add_err", 32'(got.err), 0);
    chk("add_expr_cycles", tot, 10);

    toks.delete(); add(2'b00, 4'd2); add(2'b00, 4'd6); add(2'b10, 4'd0); add(2'b11, 4'd0);
    run_expr(0, lat, tot, got);
    chk("mul_data", 32'(got.data), 12);
    chk("mul_ovf", 32'(got.ovf), 0);

    toks.delete(); add(2'b00, 4'd8); add(2'b00, 4'd2); add(2'b10, 4'd0); add(2'b11, 4'd0);
    run_expr(0, lat, tot, got);
    chk("mul_ovf_flag", 32'(got.ovf), 1);
    chk("mul_ovf_data", 32'(got.data), 0);

    toks.delete(); add(2'b00, 4'd5); add(2'b01, 4'd0); add(2'b11, 4'd0);
    run_expr(0, lat, tot, got);
    chk("under_err", 32'(got.err), 2);
    chk("under_data", 32'(got.data), 0);
    chk("under_pops", last_run, 1);
    chk("under_latency", lat, 1);

    toks.delete(); add(2'b00, 4'd1); add(2'b00, 4'd2); add(2'b11, 4'd0);
    run_expr(0, lat, tot, got);
    chk("badend_err", 32'(got.err), 3);
    chk("badend_pops", last_run, 2);
    chk("badend_latency", lat, 2);

    toks.delete(); add(2'b11, 4'd0);
    run_expr(0, lat, tot, got);
    chk("empty_end_err", 32'(got.err), 3);
    chk("empty_end_data", 32'(got.data), 0);
    chk("empty_end_pops", last_run, 0);
    chk("empty_end_latency", lat, 0);

    toks.delete();
    for (int i = 0; i < SS + 1; i++) add(2'b00, N'(i));
    add(2'b11, 4'd0);
    run_expr(0, lat, tot, got);
    chk("full_err", 32'(got.err), 1);
    chk("full_data", 32'(got.data), 0);
    chk("full_pops", last_run, 16);
    chk("full_latency", lat, 16);

    toks.delete(); add(2'b00, 4'd5); add(2'b00, 4'd6); add(2'b01, 4'd0); add(2'b11, 4'd0);
    run_expr(5, lat, tot, got);
    chk("hold_result", 32'(got.data), 11);
    chk("hold_result_err", 32'(got.err), 0);

    for (int e = 0; e < 60; e++) begin
      int len, r;
      toks.delete();
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(15, 18);
        for (int i = 0; i < len; i++) add(2'b00, N'($urandom));
      end else begin
        len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++) begin
          r = $urandom_range(0, 99);
          if (r < 55) add(2'b00, N'($urandom));
          else if (r < 75) add(2'b01, N'($urandom));
          else if (r < 92) add(2'b10, N'($urandom));
          else add(2'b11, N'($urandom));
        end
      end
      add(2'b11, N'($urandom));
      run_expr(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), lat, tot, got);
    end

    repeat (3) @(negedge clk);
    chk("final_ops_empty", exp_ops.size(), 0);
    chk("final_res_empty", exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
